// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer: owns the program counter, issues one instruction
// fetch at a time and hands each returned word to decode with its PC+4. A
// one-entry hold buffer absorbs a response that arrives while decode is
// stalled. Responses to fetches made obsolete by a redirect are squashed.
module instruction_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        Stall_IN,
    input  logic        Redirect_IN,
    input  logic [31:0] RedirectAddress_IN,
    output logic        IMemRequest_OUT,
    output logic [31:0] IMemAddress_OUT,
    input  logic        IMemReady_IN,
    input  logic        IMemResponseValid_IN,
    input  logic [31:0] IMemData_IN,
    output logic        InstructionValid_OUT,
    output logic [31:0] Instruction_OUT,
    output logic [31:0] InstructionAddressPlus4_OUT,
    output logic        AlignmentFault_OUT
);

    typedef enum logic [1:0] {
        REQUEST   = 2'd0,  // presenting FetchPC to memory
        WAIT_RESP = 2'd1,  // one fetch outstanding, result wanted
        HOLD      = 2'd2,  // result parked in the hold buffer, decode stalled
        DISCARD   = 2'd3   // one fetch outstanding, result is wrong-path
    } fetchState_t;

    // The low two bits of the vector are forced to zero so fetches stay aligned.
    localparam logic [31:0] RESET_PC = {RESET_VECTOR[31:2], 2'b00};

    fetchState_t state, stateNext;
    logic [31:0] fetchPC, fetchPCNext;
    logic [31:0] inFlightPC, inFlightPCNext;
    logic        slotValid, slotValidNext;
    logic [31:0] slotInstr, slotInstrNext;
    logic [31:0] slotPlus4, slotPlus4Next;
    logic [31:0] holdInstr, holdInstrNext;
    logic [31:0] holdPlus4, holdPlus4Next;
    logic        alignFault, alignFaultNext;

    // Request is a pure function of state; reset masks it in the same cycle.
    assign IMemRequest_OUT             = (state == REQUEST) && !RESET;
    assign IMemAddress_OUT             = fetchPC;
    assign InstructionValid_OUT        = slotValid;
    assign Instruction_OUT             = slotInstr;
    assign InstructionAddressPlus4_OUT = slotPlus4;
    assign AlignmentFault_OUT          = alignFault;

    // Next-state and datapath update; a redirect overrides every other action.
    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path
        // through the branches leaves one unassigned and no latch is inferred.
        stateNext      = state;
        fetchPCNext    = fetchPC;
        inFlightPCNext = inFlightPC;
        slotValidNext  = slotValid && Stall_IN;  // consumed unless decode stalls
        slotInstrNext  = slotInstr;
        slotPlus4Next  = slotPlus4;
        holdInstrNext  = holdInstr;
        holdPlus4Next  = holdPlus4;
        alignFaultNext = 1'b0;

        if (Redirect_IN) begin
            fetchPCNext    = {RedirectAddress_IN[31:2], 2'b00};
            slotValidNext  = 1'b0;
            holdInstrNext  = '0;
            holdPlus4Next  = '0;
            alignFaultNext = |RedirectAddress_IN[1:0];
            case (state)
                // A handshake this cycle leaves a stale fetch in memory to squash.
                REQUEST:   stateNext = IMemReady_IN ? DISCARD : REQUEST;
                WAIT_RESP: stateNext = IMemResponseValid_IN ? REQUEST : DISCARD;
                HOLD:      stateNext = REQUEST;
                DISCARD:   stateNext = IMemResponseValid_IN ? REQUEST : DISCARD;
                default:   stateNext = REQUEST;
            endcase
        end else begin
            case (state)
                REQUEST: begin
                    if (IMemReady_IN) begin
                        inFlightPCNext = fetchPC;
                        fetchPCNext    = fetchPC + 32'd4;
                        stateNext      = WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (IMemResponseValid_IN) begin
                        if (!slotValid || !Stall_IN) begin
                            slotValidNext = 1'b1;
                            slotInstrNext = IMemData_IN;
                            slotPlus4Next = inFlightPC + 32'd4;
                            stateNext     = REQUEST;
                        end else begin
                            holdInstrNext = IMemData_IN;
                            holdPlus4Next = inFlightPC + 32'd4;
                            stateNext     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!Stall_IN) begin
                        slotValidNext = 1'b1;
                        slotInstrNext = holdInstr;
                        slotPlus4Next = holdPlus4;
                        stateNext     = REQUEST;
                    end
                end
                DISCARD: begin
                    if (IMemResponseValid_IN) begin
                        stateNext = REQUEST;
                    end
                end
                default: stateNext = REQUEST;
            endcase
        end
    end

    // State register with synchronous reset back to the reset vector.
    always_ff @(posedge CLOCK) begin
        // NOTE: non-blocking assignments here, so every register samples the
        // pre-edge values regardless of statement order.
        if (RESET) begin
            state      <= REQUEST;
            fetchPC    <= RESET_PC;
            inFlightPC <= '0;
            slotValid  <= 1'b0;
            slotInstr  <= '0;
            slotPlus4  <= '0;
            holdInstr  <= '0;
            holdPlus4  <= '0;
            alignFault <= 1'b0;
        end else begin
            state      <= stateNext;
            fetchPC    <= fetchPCNext;
            inFlightPC <= inFlightPCNext;
            slotValid  <= slotValidNext;
            slotInstr  <= slotInstrNext;
            slotPlus4  <= slotPlus4Next;
            holdInstr  <= holdInstrNext;
            holdPlus4  <= holdPlus4Next;
            alignFault <= alignFaultNext;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Testbench for instruction_fetch_sequencer: directed scenarios plus a
// randomized run checked against a transaction-level model of the fetch stream.
module tb_instruction_fetch_sequencer;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        Stall_IN = 1'b0;
    logic        Redirect_IN = 1'b0;
    logic [31:0] RedirectAddress_IN = '0;
    logic        IMemRequest_OUT;
    logic [31:0] IMemAddress_OUT;
    logic        IMemReady_IN = 1'b0;
    logic        IMemResponseValid_IN = 1'b0;
    logic [31:0] IMemData_IN = '0;
    logic        InstructionValid_OUT;
    logic [31:0] Instruction_OUT;
    logic [31:0] InstructionAddressPlus4_OUT;
    logic        AlignmentFault_OUT;

    instruction_fetch_sequencer #(.RESET_VECTOR(RV)) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .Stall_IN(Stall_IN),
        .Redirect_IN(Redirect_IN),
        .RedirectAddress_IN(RedirectAddress_IN),
        .IMemRequest_OUT(IMemRequest_OUT),
        .IMemAddress_OUT(IMemAddress_OUT),
        .IMemReady_IN(IMemReady_IN),
        .IMemResponseValid_IN(IMemResponseValid_IN),
        .IMemData_IN(IMemData_IN),
        .InstructionValid_OUT(InstructionValid_OUT),
        .Instruction_OUT(Instruction_OUT),
        .InstructionAddressPlus4_OUT(InstructionAddressPlus4_OUT),
        .AlignmentFault_OUT(AlignmentFault_OUT)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int failures = 0;

    // Memory side: at most one accepted fetch awaiting its response.
    bit          pend = 1'b0;
    logic [31:0] pendAddr = '0;

    // Values seen in the current cycle, before its closing edge.
    logic        obsReq, obsValid, obsFault;
    logic [31:0] obsAddr, obsInstr, obsPc4;
    bit          obsPend;

    // Instruction memory content: a scrambled function of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    // One clock cycle: drive inputs, sample outputs, advance past the edge.
    task automatic cycle(input bit rst, input bit stall, input bit redir,
                         input logic [31:0] raddr, input bit ready, input bit resp);
        bit respNow;
        bit accepted;
        respNow = resp && pend;
        RESET = rst;
        Stall_IN = stall;
        Redirect_IN = redir;
        RedirectAddress_IN = raddr;
        IMemReady_IN = ready;
        IMemResponseValid_IN = respNow;
        IMemData_IN = respNow ? memWord(pendAddr) : 32'hDEADBEEF;
        #1;
        obsReq   = IMemRequest_OUT;
        obsAddr  = IMemAddress_OUT;
        obsValid = InstructionValid_OUT;
        obsInstr = Instruction_OUT;
        obsPc4   = InstructionAddressPlus4_OUT;
        obsFault = AlignmentFault_OUT;
        obsPend  = pend;
        accepted = (IMemRequest_OUT === 1'b1) && ready;
        @(posedge CLOCK);
        #1;
        if (respNow) pend = 1'b0;
        if (accepted) begin
            pend = 1'b1;
            pendAddr = obsAddr;
        end
    endtask

    task automatic doReset();
        cycle(1, 0, 0, '0, 0, 0);
        cycle(1, 0, 0, '0, 0, 0);
        pend = 1'b0;
    endtask

    task automatic test_reset();
        // Redirect held during reset must be overridden.
        cycle(1, 0, 1, 32'h00001236, 1, 0);
        cycle(1, 0, 1, 32'h00001236, 1, 0);
        checks++;
        if (obsReq !== 1'b0) begin
            failures++;
            $display("FAIL reset_req_in_reset got %b expected 0", obsReq);
        end
        pend = 1'b0;
        cycle(0, 0, 0, '0, 0, 0);
        checks++;
        if (obsReq !== 1'b1) begin
            failures++;
            $display("FAIL reset_req_first got %b expected 1", obsReq);
        end
        checks++;
        if (obsAddr !== RV) begin
            failures++;
            $display("FAIL reset_addr got %h expected %h", obsAddr, RV);
        end
        checks++;
        if (obsValid !== 1'b0 || obsInstr !== 32'h0 || obsPc4 !== 32'h0) begin
            failures++;
            $display("FAIL reset_slot got v=%b i=%h p=%h expected 0/0/0", obsValid, obsInstr, obsPc4);
        end
        checks++;
        if (obsFault !== 1'b0) begin
            failures++;
            $display("FAIL reset_fault got %b expected 0", obsFault);
        end
    endtask

    task automatic test_sequential();
        logic        eReq, eValid;
        logic [31:0] ePc;
        doReset();
        for (int c = 0; c < 7; c++) begin
            cycle(0, 0, 0, '0, 1, 1);
            eReq   = ((c % 2) == 0);
            eValid = ((c % 2) == 0) && (c >= 2);
            ePc    = RV + 32'(4 * (c / 2));
            checks++;
            if (obsReq !== eReq) begin
                failures++;
                $display("FAIL seq_req c=%0d got %b expected %b", c, obsReq, eReq);
            end
            if (eReq) begin
                checks++;
                if (obsAddr !== ePc) begin
                    failures++;
                    $display("FAIL seq_addr c=%0d got %h expected %h", c, obsAddr, ePc);
                end
            end
            checks++;
            if (obsValid !== eValid) begin
                failures++;
                $display("FAIL seq_valid c=%0d got %b expected %b", c, obsValid, eValid);
            end
            if (eValid) begin
                checks++;
                if (obsPc4 !== ePc || obsInstr !== memWord(ePc - 32'd4)) begin
                    failures++;
                    $display("FAIL seq_data c=%0d got %h/%h expected %h/%h",
                             c, obsPc4, obsInstr, ePc, memWord(ePc - 32'd4));
                end
            end
        end
    endtask

    task automatic test_stall();
        doReset();
        for (int c = 0; c <= 8; c++) begin
            cycle(0, (c >= 2 && c <= 6), 0, '0, (c != 8), 1);
            if (c >= 2 && c <= 7) begin
                checks++;
                if (obsValid !== 1'b1 || obsPc4 !== RV + 32'd4 || obsInstr !== memWord(RV)) begin
                    failures++;
                    $display("FAIL stall_slot c=%0d got %b/%h/%h expected 1/%h/%h",
                             c, obsValid, obsPc4, obsInstr, RV + 32'd4, memWord(RV));
                end
            end
            if (c >= 3 && c <= 7) begin
                checks++;
                if (obsReq !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_noreq c=%0d got %b expected 0", c, obsReq);
                end
            end
            if (c == 8) begin
                checks++;
                if (obsValid !== 1'b1 || obsPc4 !== RV + 32'd8 || obsInstr !== memWord(RV + 32'd4)) begin
                    failures++;
                    $display("FAIL stall_release got %b/%h/%h expected 1/%h/%h",
                             obsValid, obsPc4, obsInstr, RV + 32'd8, memWord(RV + 32'd4));
                end
                checks++;
                if (obsReq !== 1'b1 || obsAddr !== RV + 32'd8) begin
                    failures++;
                    $display("FAIL stall_resume got %b/%h expected 1/%h", obsReq, obsAddr, RV + 32'd8);
                end
            end
        end
    endtask

    task automatic test_redirect_handshake();
        doReset();
        for (int c = 0; c <= 8; c++) begin
            cycle(0, 0, (c == 4), 32'h00400020, 1, 1);
            if (c == 4) begin
                checks++;
                if (obsReq !== 1'b1 || obsAddr !== RV + 32'd8) begin
                    failures++;
                    $display("FAIL rdh_handshake got %b/%h expected 1/%h", obsReq, obsAddr, RV + 32'd8);
                end
            end
            if (c >= 5 && c <= 7) begin
                checks++;
                if (obsValid !== 1'b0) begin
                    failures++;
                    $display("FAIL rdh_squash c=%0d got %b expected 0", c, obsValid);
                end
            end
            if (c == 5) begin
                checks++;
                if (obsReq !== 1'b0 || obsFault !== 1'b0) begin
                    failures++;
                    $display("FAIL rdh_discard got req=%b fault=%b expected 0/0", obsReq, obsFault);
                end
            end
            if (c == 6) begin
                checks++;
                if (obsReq !== 1'b1 || obsAddr !== 32'h00400020) begin
                    failures++;
                    $display("FAIL rdh_target got %b/%h expected 1/00400020", obsReq, obsAddr);
                end
            end
            if (c == 8) begin
                checks++;
                if (obsValid !== 1'b1 || obsPc4 !== 32'h00400024 || obsInstr !== memWord(32'h00400020)) begin
                    failures++;
                    $display("FAIL rdh_first got %b/%h/%h expected 1/00400024/%h",
                             obsValid, obsPc4, obsInstr, memWord(32'h00400020));
                end
            end
        end
    endtask

    task automatic test_misaligned();
        doReset();
        for (int c = 0; c <= 3; c++) begin
            cycle(0, 0, (c == 0), 32'h00400022, (c != 0), 1);
            checks++;
            if (obsFault !== (c == 1)) begin
                failures++;
                $display("FAIL mis_fault c=%0d got %b expected %b", c, obsFault, (c == 1));
            end
            if (c == 1) begin
                checks++;
                if (obsReq !== 1'b1 || obsAddr !== 32'h00400020) begin
                    failures++;
                    $display("FAIL mis_addr got %b/%h expected 1/00400020", obsReq, obsAddr);
                end
            end
            if (c == 3) begin
                checks++;
                if (obsValid !== 1'b1 || obsPc4 !== 32'h00400024) begin
                    failures++;
                    $display("FAIL mis_deliver got %b/%h expected 1/00400024", obsValid, obsPc4);
                end
            end
        end
    endtask

    task automatic test_redirect_response();
        doReset();
        for (int c = 0; c <= 4; c++) begin
            cycle(0, 0, (c == 1), 32'h00001000, 1, 1);
            if (c == 2 || c == 3) begin
                checks++;
                if (obsValid !== 1'b0) begin
                    failures++;
                    $display("FAIL rdr_squash c=%0d got %b expected 0", c, obsValid);
                end
            end
            if (c == 2) begin
                checks++;
                if (obsReq !== 1'b1 || obsAddr !== 32'h00001000) begin
                    failures++;
                    $display("FAIL rdr_target got %b/%h expected 1/00001000", obsReq, obsAddr);
                end
            end
            if (c == 4) begin
                checks++;
                if (obsValid !== 1'b1 || obsPc4 !== 32'h00001004 || obsInstr !== memWord(32'h00001000)) begin
                    failures++;
                    $display("FAIL rdr_first got %b/%h/%h expected 1/00001004/%h",
                             obsValid, obsPc4, obsInstr, memWord(32'h00001000));
                end
            end
        end
    endtask

    task automatic test_wrap_and_reset();
        doReset();
        cycle(0, 0, 1, 32'hFFFFFFFC, 0, 0);
        cycle(0, 0, 0, '0, 1, 0);
        checks++;
        if (obsReq !== 1'b1 || obsAddr !== 32'hFFFFFFFC) begin
            failures++;
            $display("FAIL wrap_top got %b/%h expected 1/fffffffc", obsReq, obsAddr);
        end
        cycle(0, 0, 0, '0, 1, 1);
        cycle(0, 0, 0, '0, 1, 0);
        checks++;
        if (obsReq !== 1'b1 || obsAddr !== 32'h00000000) begin
            failures++;
            $display("FAIL wrap_addr got %b/%h expected 1/00000000", obsReq, obsAddr);
        end
        checks++;
        if (obsValid !== 1'b1 || obsPc4 !== 32'h00000000 || obsInstr !== memWord(32'hFFFFFFFC)) begin
            failures++;
            $display("FAIL wrap_pc4 got %b/%h/%h expected 1/00000000/%h",
                     obsValid, obsPc4, obsInstr, memWord(32'hFFFFFFFC));
        end
        // Reset while the fetch to 0 is outstanding; its response then arrives late.
        cycle(1, 0, 0, '0, 0, 0);
        checks++;
        if (obsReq !== 1'b0) begin
            failures++;
            $display("FAIL wrap_rst_req got %b expected 0", obsReq);
        end
        cycle(0, 0, 0, '0, 0, 1);
        checks++;
        if (obsReq !== 1'b1 || obsAddr !== RV || obsValid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_rst_state got %b/%h/%b expected 1/%h/0", obsReq, obsAddr, obsValid, RV);
        end
        cycle(0, 0, 0, '0, 1, 1);
        checks++;
        if (obsValid !== 1'b0 || obsReq !== 1'b1 || obsAddr !== RV) begin
            failures++;
            $display("FAIL wrap_stray got %b/%b/%h expected 0/1/%h", obsValid, obsReq, obsAddr, RV);
        end
        cycle(0, 0, 0, '0, 1, 1);
        cycle(0, 0, 0, '0, 1, 1);
        checks++;
        if (obsValid !== 1'b1 || obsPc4 !== RV + 32'd4 || obsInstr !== memWord(RV)) begin
            failures++;
            $display("FAIL wrap_restart got %b/%h/%h expected 1/%h/%h",
                     obsValid, obsPc4, obsInstr, RV + 32'd4, memWord(RV));
        end
    endtask

    // Random traffic checked as a stream: fetch addresses follow the PC rules,
    // each instruction decode consumes is the oldest surviving fetch, in order.
    task automatic test_random();
        logic [31:0] expQ[$];
        logic [31:0] expFetch, raddr, e, prevRaddr, prevInstr, prevPc4;
        bit          stall, redir, ready, resp;
        bit          prevRedir, prevStall, prevValid;
        int          consumed;
        doReset();
        expFetch  = RV;
        consumed  = 0;
        prevRedir = 0;
        prevStall = 0;
        prevValid = 0;
        prevRaddr = '0;
        prevInstr = '0;
        prevPc4   = '0;
        for (int n = 0; n < 3000; n++) begin
            stall = ($urandom_range(0, 9) < 3) && (n < 2980);
            redir = ($urandom_range(0, 19) == 0) && (n < 2980);
            raddr = $urandom;
            if ($urandom_range(0, 1) == 1) raddr[1:0] = 2'b00;
            ready = ($urandom_range(0, 9) < 6) || (n >= 2980);
            resp  = ($urandom_range(0, 9) < 6) || (n >= 2980);
            cycle(0, stall, redir, raddr, ready, resp);

            checks++;
            if (obsFault !== (prevRedir && (prevRaddr[1:0] != 2'b00))) begin
                failures++;
                $display("FAIL rnd_fault n=%0d got %b", n, obsFault);
            end
            if (prevRedir) begin
                checks++;
                if (obsValid !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_redir_valid n=%0d got %b expected 0", n, obsValid);
                end
            end
            if (prevValid && prevStall && !prevRedir) begin
                checks++;
                if (obsValid !== 1'b1 || obsPc4 !== prevPc4 || obsInstr !== prevInstr) begin
                    failures++;
                    $display("FAIL rnd_stable n=%0d got %b/%h/%h expected 1/%h/%h",
                             n, obsValid, obsPc4, obsInstr, prevPc4, prevInstr);
                end
            end
            if (obsReq === 1'b1) begin
                checks++;
                if (obsAddr !== expFetch || obsPend) begin
                    failures++;
                    $display("FAIL rnd_req n=%0d got %h pend=%b expected %h pend=0",
                             n, obsAddr, obsPend, expFetch);
                end
            end
            if (obsValid === 1'b1 && !stall && !redir) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra n=%0d got %h expected none", n, obsPc4);
                end else begin
                    e = expQ.pop_front();
                    consumed++;
                    if (obsPc4 !== e || obsInstr !== memWord(e - 32'd4)) begin
                        failures++;
                        $display("FAIL rnd_order n=%0d got %h/%h expected %h/%h",
                                 n, obsPc4, obsInstr, e, memWord(e - 32'd4));
                    end
                end
            end

            if (redir) begin
                expQ.delete();
                expFetch = {raddr[31:2], 2'b00};
            end else if (obsReq === 1'b1 && ready) begin
                expQ.push_back(expFetch + 32'd4);
                expFetch = expFetch + 32'd4;
            end
            prevRedir = redir;
            prevRaddr = raddr;
            prevStall = stall;
            prevValid = (obsValid === 1'b1);
            prevPc4   = obsPc4;
            prevInstr = obsInstr;
        end
        checks++;
        if (consumed < 100) begin
            failures++;
            $display("FAIL rnd_progress got %0d delivered expected at least 100", consumed);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_handshake();
        test_misaligned();
        test_redirect_response();
        test_wrap_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
